// File: rtl/trap_ctrl_pkg.sv
// Shared constants for the trap controller: register offsets, FSM encodings and the core's trap-entry address.
package trap_ctrl_pkg;

   // Word address the core writes the saved PC to on trap entry.
   localparam logic [31:0] TRAP_ADDR = 32'h0000_00F0;

   localparam logic [2:0] TRAPC_PENDING = 3'd0;
   localparam logic [2:0] TRAPC_ENABLE  = 3'd1;
   localparam logic [2:0] TRAPC_CAUSE   = 3'd2;
   localparam logic [2:0] TRAPC_EPC     = 3'd3;
   localparam logic [2:0] TRAPC_CTRL    = 3'd4;

   localparam logic [1:0] TRAPC_IDLE = 2'd0;
   localparam logic [1:0] TRAPC_REQ  = 2'd1;
   localparam logic [1:0] TRAPC_SERV = 2'd2;

   function automatic logic [31:0] cause_word(input logic vld, input logic [4:0] idx);
      return {vld, 26'd0, idx};
   endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// Core data-bus control signals seen by memory-mapped peripherals.
interface trap_ctrl_if;
   logic        strobe;
   logic        mem_rw;
   logic [31:0] d_addr;

   modport master (output strobe, output mem_rw, output d_addr);
   modport slave  (input  strobe, input  mem_rw, input  d_addr);
endinterface

// File: rtl/trap_pending.sv
// Source rising-edge detect and PENDING register with write-1-to-clear; a new edge beats a clear on the same bit.
module trap_pending #(
   parameter int NSRC = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NSRC-1:0] i_src,
   input  logic            i_clr_vld,
   input  logic [NSRC-1:0] i_clr_dat,
   output logic [NSRC-1:0] o_pending
);
   logic [NSRC-1:0] r_src_q;
   logic [NSRC-1:0] r_pending;
   logic            r_armed;
   logic [NSRC-1:0] w_edge;
   logic [NSRC-1:0] w_clr;

   // History is cleared by reset, so edge detection waits one cycle after release:
   // a source already high when reset lifts is not a new event.
   assign w_edge    = i_src & ~r_src_q & {NSRC{r_armed}};
   assign w_clr     = i_clr_vld ? i_clr_dat : '0;
   assign o_pending = r_pending;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_src_q   <= '0;
         r_pending <= '0;
         r_armed   <= 1'b0;
      end else begin
         r_src_q   <= i_src;
         r_armed   <= 1'b1;
         r_pending <= (r_pending & ~w_clr) | w_edge;
      end
   end
endmodule

// File: rtl/trap_ctrl.sv
// Memory-mapped trap controller: register decode, trap FSM, and the combinational read path onto d_data.
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter logic [31:0] BASE = 32'h0000_0100,
   parameter int          NSRC = 8
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NSRC-1:0] src,
   trap_ctrl_if.slave      bus,
   inout  wire  [31:0]     d_data,
   output logic            trap,
   output logic            gie
);
   logic [1:0]      r_state;
   logic            r_trap;
   logic            r_gie;
   logic [NSRC-1:0] r_enable;
   logic            r_cause_vld;
   logic [4:0]      r_cause_idx;
   logic [31:0]     r_epc;

   logic [31:0]     w_off_full;
   logic [2:0]      w_off;
   logic            w_hit;
   logic            w_wr;
   logic            w_rd;
   logic            w_ctrl_wr;
   logic            w_trap_wr;
   logic [NSRC-1:0] w_pending;
   logic [NSRC-1:0] w_act;
   logic            w_req;
   logic [4:0]      w_src_idx;
   logic [31:0]     w_rd_dat;

   assign w_off_full = bus.d_addr - BASE;
   assign w_off      = w_off_full[2:0];
   assign w_hit      = bus.strobe && (bus.d_addr >= BASE) && (w_off_full < 32'd5);
   assign w_wr       = w_hit & bus.mem_rw;
   assign w_rd       = w_hit & ~bus.mem_rw;
   assign w_ctrl_wr  = w_wr && (w_off == TRAPC_CTRL);
   assign w_trap_wr  = bus.strobe & bus.mem_rw & (bus.d_addr == TRAP_ADDR);

   trap_pending #(.NSRC(NSRC)) u_pending (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_src     (src),
      .i_clr_vld (w_wr && (w_off == TRAPC_PENDING)),
      .i_clr_dat (d_data[NSRC-1:0]),
      .o_pending (w_pending)
   );

   assign w_act = w_pending & r_enable;
   assign w_req = r_gie & (|w_act);

   // Lowest index wins, so scan from the top down.
   always_comb begin
      w_src_idx = '0;
      for (int i = NSRC - 1; i >= 0; i--) begin
         if (w_act[i]) w_src_idx = 5'(i);
      end
   end

   always_comb begin
      w_rd_dat = '0;
      case (w_off)
         TRAPC_PENDING: w_rd_dat = 32'(w_pending);
         TRAPC_ENABLE:  w_rd_dat = 32'(r_enable);
         TRAPC_CAUSE:   w_rd_dat = cause_word(r_cause_vld, r_cause_idx);
         TRAPC_EPC:     w_rd_dat = r_epc;
         TRAPC_CTRL:    w_rd_dat = {31'd0, r_gie};
         default:       w_rd_dat = '0;
      endcase
   end

   // The core samples read data on the same edge it presents the address.
   assign d_data = w_rd ? w_rd_dat : 32'bz;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state     <= TRAPC_IDLE;
         r_trap      <= 1'b0;
         r_gie       <= 1'b0;
         r_enable    <= '0;
         r_cause_vld <= 1'b0;
         r_cause_idx <= '0;
         r_epc       <= '0;
      end else begin
         if (w_wr && (w_off == TRAPC_ENABLE)) r_enable <= d_data[NSRC-1:0];

         case (r_state)
            TRAPC_IDLE: begin
               if (w_ctrl_wr) r_gie <= d_data[0];
               if (w_req) begin
                  r_state     <= TRAPC_REQ;
                  r_trap      <= 1'b1;
                  r_cause_vld <= 1'b1;
                  r_cause_idx <= w_src_idx;
               end
            end
            // Once requested, only the core's trap-entry write retires the trap.
            TRAPC_REQ: begin
               if (w_trap_wr) begin
                  r_epc   <= d_data;
                  r_trap  <= 1'b0;
                  r_gie   <= 1'b0;
                  r_state <= TRAPC_SERV;
               end else if (w_ctrl_wr) begin
                  r_gie <= d_data[0];
               end
            end
            TRAPC_SERV: begin
               if (w_ctrl_wr && d_data[0]) begin
                  r_gie   <= 1'b1;
                  r_state <= TRAPC_IDLE;
               end
            end
            default: begin
               r_state <= TRAPC_IDLE;
               r_trap  <= 1'b0;
            end
         endcase
      end
   end

   assign trap = r_trap;
   assign gie  = r_gie;
endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: hand-computed expectations for reset, trap entry/return, W1C priority and bus release.
module tb_trap_ctrl;
   import trap_ctrl_pkg::*;

   localparam logic [31:0] BASE = 32'h0000_0100;
   localparam int          NSRC = 8;

   logic            clk = 1'b0;
   logic            reset_n;
   logic [NSRC-1:0] src;
   logic            trap;
   logic            gie;
   logic [31:0]     tb_drv;
   logic            tb_oe;
   tri1  [31:0]     d_data;

   int n_checks = 0;
   int n_errs   = 0;

   trap_ctrl_if bus ();

   assign d_data = tb_oe ? tb_drv : 32'bz;

   trap_ctrl #(.BASE(BASE), .NSRC(NSRC)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .src     (src),
      .bus     (bus),
      .d_data  (d_data),
      .trap    (trap),
      .gie     (gie)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errs++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      bus.strobe = 1'b1;
      bus.mem_rw = 1'b1;
      bus.d_addr = addr;
      tb_drv     = data;
      tb_oe      = 1'b1;
      tick();
      bus.strobe = 1'b0;
      bus.mem_rw = 1'b0;
      tb_oe      = 1'b0;
   endtask

   // Unselected bus reads as the pull-up value.
   task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
      bus.strobe = 1'b1;
      bus.mem_rw = 1'b0;
      bus.d_addr = addr;
      #1;
      check(tag, d_data, exp);
      bus.strobe = 1'b0;
      #1;
   endtask

   initial begin
      reset_n    = 1'b0;
      src        = 8'hFF;
      bus.strobe = 1'b0;
      bus.mem_rw = 1'b0;
      bus.d_addr = '0;
      tb_drv     = '0;
      tb_oe      = 1'b0;

      // Reset with all sources high
      tick(); tick(); tick();
      check("rst_trap", {31'd0, trap}, 32'd0);
      check("rst_gie",  {31'd0, gie},  32'd0);
      check("rst_bus_idle", d_data, 32'hFFFF_FFFF);
      read_check("rst_pending", BASE + 0, 32'd0);
      read_check("rst_enable",  BASE + 1, 32'd0);
      read_check("rst_cause",   BASE + 2, 32'd0);
      read_check("rst_epc",     BASE + 3, 32'd0);
      read_check("rst_ctrl",    BASE + 4, 32'd0);
      reset_n = 1'b1;
      tick(); tick();
      read_check("no_edge_after_rst", BASE + 0, 32'd0);
      src = 8'h00;
      tick();

      // Enable sources 2 and 3, arm, then pulse src[3] followed by src[2]
      bus_write(BASE + 1, 32'hFFFF_FF0C);
      read_check("enable_upper_zero", BASE + 1, 32'h0000_000C);
      bus_write(BASE + 4, 32'd1);
      check("gie_set", {31'd0, gie}, 32'd1);
      src = 8'h08;
      tick();
      check("trap_lat1", {31'd0, trap}, 32'd0);
      src = 8'h04;
      tick();
      check("trap_lat2", {31'd0, trap}, 32'd1);
      src = 8'h00;
      read_check("cause_src3", BASE + 2, 32'h8000_0003);
      read_check("pending_both", BASE + 0, 32'h0000_000C);

      // REQ is committed against ENABLE and GIE changes
      bus_write(BASE + 1, 32'd0);
      check("req_enable0_trap", {31'd0, trap}, 32'd1);
      bus_write(BASE + 1, 32'h0000_000C);
      bus_write(BASE + 4, 32'd0);
      check("req_gie0_gie", {31'd0, gie}, 32'd0);
      check("req_gie0_trap", {31'd0, trap}, 32'd1);

      // Trap entry
      bus_write(TRAP_ADDR, 32'h0000_1234);
      check("ack_trap", {31'd0, trap}, 32'd0);
      check("ack_gie",  {31'd0, gie},  32'd0);
      read_check("epc_1234", BASE + 3, 32'h0000_1234);
      bus_write(BASE + 0, 32'h0000_0008);
      read_check("w1c_bit3", BASE + 0, 32'h0000_0004);
      bus_write(BASE + 4, 32'd1);
      check("rearm_gie", {31'd0, gie}, 32'd1);
      check("rearm_trap0", {31'd0, trap}, 32'd0);
      tick();
      check("refire_trap", {31'd0, trap}, 32'd1);
      read_check("cause_src2", BASE + 2, 32'h8000_0002);

      // Service source 2 and return cleanly
      bus_write(TRAP_ADDR, 32'h0000_5678);
      read_check("epc_5678", BASE + 3, 32'h0000_5678);
      bus_write(BASE + 0, 32'h0000_0004);
      bus_write(BASE + 4, 32'd1);
      tick();
      check("quiet_after_return", {31'd0, trap}, 32'd0);

      // Edge and W1C on the same bit in the same cycle
      src = 8'h01;
      bus_write(BASE + 0, 32'h0000_0001);
      read_check("set_beats_clr", BASE + 0, 32'h0000_0001);
      check("disabled_no_trap", {31'd0, trap}, 32'd0);
      src = 8'h00;
      bus_write(BASE + 0, 32'h0000_0001);
      read_check("w1c_bit0", BASE + 0, 32'd0);

      // Trap-entry write outside REQ is ignored
      bus_write(TRAP_ADDR, 32'h0000_DEAD);
      read_check("epc_ignored", BASE + 3, 32'h0000_5678);
      check("idle_trap_addr_trap", {31'd0, trap}, 32'd0);

      // Reset while in REQ
      src = 8'h08;
      tick();
      src = 8'h00;
      tick();
      check("pre_rst_trap", {31'd0, trap}, 32'd1);
      reset_n = 1'b0;
      tick();
      check("rst_req_trap", {31'd0, trap}, 32'd0);
      check("rst_req_gie",  {31'd0, gie},  32'd0);
      reset_n = 1'b1;
      read_check("rst_req_cause", BASE + 2, 32'd0);
      read_check("rst_req_enable", BASE + 1, 32'd0);
      read_check("unmapped_z", BASE + 5, 32'hFFFF_FFFF);
      check("idle_bus_z", d_data, 32'hFFFF_FFFF);
      tick(); tick();

      // FSM restarts from IDLE after reset
      bus_write(BASE + 1, 32'h0000_0008);
      bus_write(BASE + 4, 32'd1);
      src = 8'h08;
      tick();
      src = 8'h00;
      tick();
      check("post_rst_trap", {31'd0, trap}, 32'd1);
      read_check("post_rst_cause", BASE + 2, 32'h8000_0003);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
      $finish;
   end
endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Memory-mapped trap (interrupt) controller on the core's data bus; produces the core's `trap` input.
- Latches rising edges on external sources and raises `trap` when any enabled source is pending and traps are globally enabled.
- Recognises the core's trap-entry write to `TRAP_ADDR` as the acknowledge: captures the saved PC and lowers `trap`.
- Software returns by re-arming the global enable.

Parameters:
- BASE, 32'h0000_0100: word address of register 0; registers occupy BASE..BASE+4. This window must not contain `TRAP_ADDR`.
- NSRC, 8: number of trap sources, 1..31.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- src  in  NSRC  asynchronous-free level sources; the block detects rising edges
- strobe  in  1  core data-bus strobe
- mem_rw  in  1  1 = write, 0 = read; qualified by strobe
- d_addr  in  32  core data address (word)
- d_data  inout  32  core data bus; driven only during a selected read, else 32'bz
- trap  out  1  trap request to the core
- gie  out  1  global trap enable (status, for debug LEDs and benches)

Behaviour:
- Reset (clk edge with reset_n=0):
  - trap=0, gie=0, state=IDLE.
  - PENDING, ENABLE, CAUSE, EPC all 0; src history = 0.
  - d_data is z. Reset dominates any simultaneous bus cycle.
- Register map (offset from BASE):
  - 0 PENDING: read; write-1-to-clear.
  - 1 ENABLE: read/write; low NSRC bits; upper bits read 0.
  - 2 CAUSE: read only; bit31 = valid, bits4:0 = source index.
  - 3 EPC: read only.
  - 4 CTRL: bit0 = GIE, read/write.
  - Unmapped offsets and writes to read-only registers are ignored; no bus response.
- Reads: `d_data` is combinational from `d_addr` while strobe & !mem_rw & hit. Zero-cycle latency, because the core samples `d_data` on the same edge.
- Writes: commit at the clk edge where strobe & mem_rw & hit.
- Pending:
  - PENDING[i] sets on the edge after src[i] goes 0->1 (src registered once; edge = src & ~src_q).
  - A set and a W1C on the same bit in the same cycle: set wins.
- req = gie & |(PENDING & ENABLE).
- FSM:
  - IDLE: if req, go to REQ, assert trap. Latch CAUSE = {1, lowest-index pending-and-enabled source}.
  - REQ: trap=1. When strobe & mem_rw & d_addr==`TRAP_ADDR`: EPC <= d_data, trap <= 0, gie <= 0, go to SERV. REQ is committed: clearing ENABLE, PENDING or GIE while in REQ does not drop trap.
  - SERV: trap=0. A CTRL write with bit0=1 sets gie and returns to IDLE; the next trap needs req re-evaluated in IDLE, at least one cycle later.
  - A `TRAP_ADDR` write outside REQ is ignored (EPC unchanged).
  - A CTRL write of GIE in IDLE or REQ updates gie only. Writing GIE=0 in SERV has no effect.
- Software must clear the serviced PENDING bit before re-arming; otherwise a trap re-fires immediately.
- Overall latency: src rising edge -> trap high is 2 cycles (edge detect, then PENDING -> FSM).
- CAUSE.valid stays set until the next trap entry overwrites CAUSE; reset clears it.

Decomposition:
- Add to common.vh:
  - `TRAPC_PENDING`, `TRAPC_ENABLE`, `TRAPC_CAUSE`, `TRAPC_EPC`, `TRAPC_CTRL` offsets.
  - FSM encodings `TRAPC_IDLE`, `TRAPC_REQ`, `TRAPC_SERV`.
  - Reuse the existing `TRAP_ADDR`.
- One sub-module, trap_pending (NSRC): src edge detect plus PENDING register with W1C and set priority. The top level holds the FSM, registers and bus decode.

Test Plan:
- Reset with src=8'hFF held: trap=0, reads of all five registers return 0. Releasing reset with src still high sets no PENDING bit (no edge).
- ENABLE=8'h0C, GIE=1, pulse src[3] then src[2] the following cycle: trap rises 2 cycles after src[3]. CAUSE reads 32'h8000_0003 (latched at REQ entry, before src[2] is pending).
- While trap=1, bus write d_addr=`TRAP_ADDR`, d_data=32'h0000_1234: next cycle trap=0, gie=0, EPC=32'h1234. Write PENDING=8'h08, then CTRL=1: with src[2] still pending, trap rises again with CAUSE=0x80000002.
- Write PENDING=8'h01 in the same cycle src[0] rises: PENDING[0] reads 1.
- In IDLE, write `TRAP_ADDR` with 32'hDEAD: EPC unchanged, trap stays 0. In REQ, write ENABLE=0: trap stays 1 until the `TRAP_ADDR` write.
- Assert reset_n=0 for one cycle while in REQ: trap=0 and gie=0 on that edge, state IDLE. d_data is z on all non-selected cycles, and on reads at BASE+5.
